// File: rtl/spi_xfer_fsm.sv
// -----------------------------------------------------------------------------
// spi_xfer_fsm
//
// Control sequencer for the SPI memory-slave datapath. Runs on clk and reacts
// to single-cycle sclk rising-edge strobes and a synchronised chip select.
// It frames one SPI transaction as:
//   ADDR_W address bits -> 1 R/W bit -> DATA_W data bits (MSB first)
// and issues the address-latch, shift-register-load, memory-write and
// MISO-enable controls for the datapath.
//
// Build option:
//   SPI_BURST_EN  when defined, every completed data word is followed by an
//                 address increment and the next word of the same direction,
//                 until chip select is released.
//
// Parameters:
//   ADDR_W     address bits per frame (>= 1)
//   DATA_W     data bits per word (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   sclk_pos   one-clk strobe per sclk rising edge
//   cs_n       synchronised chip select, active low
//   r_or_w     shift-register LSB, valid the cycle after sclk_pos (1 = write)
//   addr_wr    address latch enable pulse
//   s_r        shift-register parallel load pulse
//   dm_wr      data memory write enable pulse
//   addr_inc   address increment pulse (burst builds only, otherwise 0)
//   miso_en    MISO tristate enable (level)
//   busy       high while the sequencer is not idle
//   frame_err  sticky frame error, cleared when a new frame starts
// -----------------------------------------------------------------------------
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | chip select released, all outputs low
// ADDR      | shifting address bits plus the R/W bit
// DECODE    | address latched, R/W bit selects the data phase
// RD_LOAD   | shift register loads memory read data, MISO driven from here
// RD_DATA   | shifting read data out
// WR_DATA   | shifting write data in
// WR_COMMIT | full write word received, memory written
// INC       | burst only: address increment before the next word
// DONE      | frame finished, waiting for chip select release
// -----------------------------------------------------------------------------
module spi_xfer_fsm #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pos,
  input  logic cs_n,
  input  logic r_or_w,
  output logic addr_wr,
  output logic s_r,
  output logic dm_wr,
  output logic addr_inc,
  output logic miso_en,
  output logic busy,
  output logic frame_err
);

  localparam int CNT_MAX = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The address phase also carries the R/W bit, so it ends on strobe ADDR_W+1.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    DECODE    = 4'd2,
    RD_LOAD   = 4'd3,
    RD_DATA   = 4'd4,
    WR_DATA   = 4'd5,
    WR_COMMIT = 4'd6,
    DONE      = 4'd7
`ifdef SPI_BURST_EN
    ,
    INC       = 4'd8
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             addr_wr_q, addr_wr_d;
  logic             s_r_q, s_r_d;
  logic             dm_wr_q, dm_wr_d;
  logic             miso_en_q, miso_en_d;
  logic             busy_q, busy_d;
`ifdef SPI_BURST_EN
  // Direction of the current frame, needed to pick the next word after INC.
  logic             is_wr_q, is_wr_d;
  logic             addr_inc_q, addr_inc_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
`ifdef SPI_BURST_EN
    is_wr_d     = is_wr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!cs_n) begin
          state_d     = ADDR;
          cnt_d       = '0;
          frame_err_d = 1'b0;
        end
      end

      ADDR: begin
        if (sclk_pos) begin
          if (cnt_q == ADDR_LAST) begin
            state_d = DECODE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DECODE: begin
        // Strobes in one-cycle states are dropped and flagged.
        if (sclk_pos) frame_err_d = 1'b1;
        cnt_d   = '0;
        state_d = r_or_w ? WR_DATA : RD_LOAD;
`ifdef SPI_BURST_EN
        is_wr_d = r_or_w;
`endif
      end

      RD_LOAD: begin
        if (sclk_pos) frame_err_d = 1'b1;
        cnt_d   = '0;
        state_d = RD_DATA;
      end

      RD_DATA: begin
        if (sclk_pos) begin
          if (cnt_q == DATA_LAST) begin
`ifdef SPI_BURST_EN
            state_d = INC;
`else
            state_d = DONE;
`endif
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR_DATA: begin
        if (sclk_pos) begin
          if (cnt_q == DATA_LAST) begin
            state_d = WR_COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR_COMMIT: begin
        if (sclk_pos) frame_err_d = 1'b1;
`ifdef SPI_BURST_EN
        state_d = INC;
`else
        state_d = DONE;
`endif
      end

`ifdef SPI_BURST_EN
      INC: begin
        if (sclk_pos) frame_err_d = 1'b1;
        cnt_d   = '0;
        state_d = is_wr_q ? WR_DATA : RD_LOAD;
      end
`endif

      DONE: begin
        // Any clock beyond the frame length is an overrun.
        if (sclk_pos) frame_err_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Chip-select release aborts from anywhere; a partial write never commits
    // because WR_COMMIT is only entered with cs_n still low.
    if (cs_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    // Outputs are a function of the next state so they are registered and
    // line up with the state they belong to.
    addr_wr_d = (state_d == DECODE);
    s_r_d     = (state_d == RD_LOAD);
    dm_wr_d   = (state_d == WR_COMMIT);
    busy_d    = (state_d != IDLE);
`ifdef SPI_BURST_EN
    addr_inc_d = (state_d == INC);
`endif

    unique case (state_d)
      RD_LOAD, RD_DATA: miso_en_d = 1'b1;
      DONE:             miso_en_d = miso_en_q;
`ifdef SPI_BURST_EN
      // Keep MISO driven across the increment between burst read words.
      INC:              miso_en_d = miso_en_q;
`endif
      default:          miso_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      addr_wr_q   <= 1'b0;
      s_r_q       <= 1'b0;
      dm_wr_q     <= 1'b0;
      miso_en_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_BURST_EN
      is_wr_q     <= 1'b0;
      addr_inc_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      addr_wr_q   <= addr_wr_d;
      s_r_q       <= s_r_d;
      dm_wr_q     <= dm_wr_d;
      miso_en_q   <= miso_en_d;
      busy_q      <= busy_d;
`ifdef SPI_BURST_EN
      is_wr_q     <= is_wr_d;
      addr_inc_q  <= addr_inc_d;
`endif
    end
  end

  assign addr_wr   = addr_wr_q;
  assign s_r       = s_r_q;
  assign dm_wr     = dm_wr_q;
  assign miso_en   = miso_en_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SPI_BURST_EN
  assign addr_inc  = addr_inc_q;
`else
  assign addr_inc  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_fsm
//
// Drives two instances of spi_xfer_fsm (default 7/8 geometry and a 15/16
// geometry) with the same chip-select / sclk strobe stream. Each DUT gets its
// own r_or_w stream so its R/W bit lands at its own frame position. Expected
// outputs per cycle come from a frame-level model: strobe arrival times plus
// the frame rules (address length, data length, chip-select release time).
// -----------------------------------------------------------------------------
module tb_spi_xfer_fsm;

  logic clk = 1'b0;
  logic reset, sclk_pos, cs_n, rw1, rw2;
  logic aw1, sr1, dw1, ai1, me1, bz1, fe1;
  logic aw2, sr2, dw2, ai2, me2, bz2, fe2;

  int n_tests = 0;
  int n_fail  = 0;
  int st [0:63];
  bit err1, err2;

  always #5 clk = ~clk;

  spi_xfer_fsm #(.ADDR_W(7), .DATA_W(8)) dut1 (
    .clk(clk), .reset(reset), .sclk_pos(sclk_pos), .cs_n(cs_n), .r_or_w(rw1),
    .addr_wr(aw1), .s_r(sr1), .dm_wr(dw1), .addr_inc(ai1), .miso_en(me1),
    .busy(bz1), .frame_err(fe1)
  );

  spi_xfer_fsm #(.ADDR_W(15), .DATA_W(16)) dut2 (
    .clk(clk), .reset(reset), .sclk_pos(sclk_pos), .cs_n(cs_n), .r_or_w(rw2),
    .addr_wr(aw2), .s_r(sr2), .dm_wr(dw2), .addr_inc(ai2), .miso_en(me2),
    .busy(bz2), .frame_err(fe2)
  );

  wire [6:0] o1 = {bz1, aw1, sr1, dw1, me1, ai1, fe1};
  wire [6:0] o2 = {bz2, aw2, sr2, dw2, me2, ai2, fe2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int t, input logic [6:0] obs,
                       input logic [6:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed={busy,aw,sr,dw,miso,inc,err}=%b expected=%b",
             tag, t, obs, exp);
    end
  endtask

  // Expected outputs observed just after clk edge t of a frame. Edge 0 samples
  // the chip-select fall, st[k] is the edge sampling strobe k, r is the edge
  // sampling chip-select high again. Returns {busy,aw,sr,dw,miso,inc,err}.
  function automatic logic [6:0] model(input int a, input int d, input int t,
                                       input int r, input int n, input bit rw,
                                       input bit err_prev);
    logic b, aw, sr, dw, me, ai, fe;
    b = 0; aw = 0; sr = 0; dw = 0; me = 0; ai = 0; fe = 0;
    if (t < 0) return {6'b0, err_prev};
`ifndef SPI_BURST_EN
    // Strobes beyond a full frame arrive in DONE.
    fe = (n > a + d + 1) && (t >= st[a + d + 1]);
`endif
    if (t < r) begin
      b  = 1;
      aw = (n > a) && (t == st[a]);
      if (!rw) begin
        sr = (n > a) && (t == st[a] + 1);
        me = (n > a) && (t > st[a]);
      end
`ifdef SPI_BURST_EN
      for (int w = 1; a + w * d < n; w++) begin
        int e;
        e = st[a + w * d];
        if (!rw) begin
          ai = ai | (t == e);
          sr = sr | (t == e + 1);
        end else begin
          dw = dw | (t == e);
          ai = ai | (t == e + 1);
        end
      end
`else
      if (rw) dw = (n > a + d) && (t == st[a + d]);
`endif
    end
    return {b, aw, sr, dw, me, ai, fe};
  endfunction

  // Serial bit k of a 7/8 frame (address MSB first, R/W, data MSB first).
  function automatic bit bit1(input int k, input bit rw, input logic [6:0] addr,
                              input logic [7:0] data);
    if (k < 7)  return addr[6 - k];
    if (k == 7) return rw;
    if (k < 16) return data[15 - k];
    return 1'b0;
  endfunction

  task automatic run_frame(input string tag, input bit rw, input int n,
                           input int per, input int gap, input int tail,
                           input logic [6:0] addr, input logic [7:0] data);
    int r, kk;
    bit strobe;
    logic [6:0] e1, e2;
    e1 = '0; e2 = '0;
    for (int k = 0; k < n; k++) st[k] = gap + k * per;
    r = (n == 0) ? gap + 2 : st[n - 1] + tail;
    for (int t = -1; t <= r + 3; t++) begin
      cs_n   = !(t >= 0 && t < r);
      strobe = 0;
      kk     = -1;
      for (int k = 0; k < n; k++) if (st[k] == t) begin strobe = 1; kk = k; end
      sclk_pos = strobe;
      tick();
      e1 = model(7, 8, t, r, n, rw, err1);
      e2 = model(15, 16, t, r, n, rw, err2);
      check({tag, "/a7d8"}, t, o1, e1);
      check({tag, "/a15d16"}, t, o2, e2);
      if (strobe) begin
        rw1 = bit1(kk, rw, addr, data);
        rw2 = (kk == 15) ? rw : bit1(kk, rw, addr, data);
      end
    end
    sclk_pos = 0;
    err1 = e1[0];
    err2 = e2[0];
  endtask

  task automatic random_frames(input int count);
    for (int i = 0; i < count; i++) begin
      run_frame("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(4, 9)), int'($urandom_range(1, 4)),
                int'($urandom_range(2, 6)), 7'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    reset = 1; cs_n = 1; sclk_pos = 0; rw1 = 0; rw2 = 0; err1 = 0; err2 = 0;
    repeat (3) tick();
    check("reset/a7d8", 0, o1, 7'b0);
    check("reset/a15d16", 0, o2, 7'b0);
    reset = 0;
    tick();
    check("idle/a7d8", 1, o1, 7'b0);
    check("idle/a15d16", 1, o2, 7'b0);

    run_frame("write",   1, 16, 8, 3, 4, 7'h15, 8'hA5);
    run_frame("read",    0, 16, 8, 3, 4, 7'h15, 8'hA5);
    run_frame("abort",   1, 12, 8, 3, 3, 7'h15, 8'hA5);
    run_frame("overrun", 1, 17, 8, 3, 4, 7'h15, 8'hA5);
    run_frame("errclr",  0, 5,  6, 2, 3, 7'h2A, 8'h3C);
    run_frame("sweep",   1, 32, 4, 2, 3, 7'h55, 8'hC3);
    run_frame("burstrd", 0, 32, 8, 3, 4, 7'h15, 8'h5A);
    run_frame("burstwr", 1, 40, 4, 1, 2, 7'h01, 8'hFF);
    run_frame("empty",   0, 0,  4, 3, 2, 7'h00, 8'h00);
    random_frames(25);

    // Reset in the middle of a frame after an overrun has set frame_err.
    cs_n = 0;
    rw1 = 1;
    rw2 = 1;
    for (int i = 0; i < 80; i++) begin
      sclk_pos = (i % 4 == 2);
      tick();
    end
    sclk_pos = 0;
    reset = 1;
    tick();
    check("midreset/a7d8", 0, o1, 7'b0);
    check("midreset/a15d16", 0, o2, 7'b0);
    reset = 0;
    cs_n  = 1;
    tick();
    check("postreset/a7d8", 1, o1, 7'b0);
    check("postreset/a15d16", 1, o2, 7'b0);
    err1 = 0;
    err2 = 0;

    random_frames(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
